// File: rtl/key_debouncer.sv
// key_debouncer
// Synchronises the raw active-low DE10-Lite push buttons to MAX10_CLK1_50,
// rejects contact bounce with a per-key stability counter and produces clean
// active-high levels plus one-cycle press, release and long-press pulses.
// Every key channel is fully independent of the others.
//
// Debounce counting: on entry to a pending state the counter loads 1, which
// accounts for the sample that triggered the entry. While pending, the
// counter holds the number of agreeing samples seen before the current one.
// A change is accepted once the current sample completes a run of
// DEBOUNCE_CYCLES agreeing samples. With DEBOUNCE_CYCLES = 1 the pending
// state is left on its first cycle.
module key_debouncer #(
  parameter int NUM_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic                MAX10_CLK1_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES) + 1;

  // Counter value at which the current sample completes a stable run.
  localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } key_state_t;

  logic [NUM_KEYS-1:0] sync_1;
  logic [NUM_KEYS-1:0] sync_2;

  // Two-stage synchroniser for the asynchronous KEY pins, idling released.
  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      sync_1 <= KEY;
      sync_2 <= sync_1;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_state_t        state_q;
    key_state_t        state_nxt;
    logic [DEB_W-1:0]  deb_cnt_q;
    logic [DEB_W-1:0]  deb_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt_inc;
    logic              pressed_s;
    logic              level_nxt;
    logic              press_nxt;
    logic              release_nxt;
    logic              long_nxt;
    logic              level_q;
    logic              press_q;
    logic              release_q;
    logic              long_q;

    assign pressed_s = ~sync_2[k];

    assign hold_cnt_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q
                                                   : hold_cnt_q + HOLD_W'(1);

    // State and counter register for this key's debounce FSM.
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
      if (reset) begin
        state_q    <= RELEASED;
        deb_cnt_q  <= '0;
        hold_cnt_q <= '0;
      end else begin
        state_q    <= state_nxt;
        deb_cnt_q  <= deb_cnt_nxt;
        hold_cnt_q <= hold_cnt_nxt;
      end
    end

    // Next-state logic: a change is accepted only after a full stable run.
    always_comb begin
      state_nxt    = state_q;
      deb_cnt_nxt  = deb_cnt_q;
      hold_cnt_nxt = hold_cnt_q;
      unique case (state_q)
        RELEASED: begin
          hold_cnt_nxt = '0;
          if (pressed_s) begin
            state_nxt   = PRESS_PEND;
            deb_cnt_nxt = DEB_W'(1);
          end
        end
        PRESS_PEND: begin
          if (!pressed_s) begin
            state_nxt   = RELEASED;
            deb_cnt_nxt = '0;
          end else if (deb_cnt_q >= DEB_LAST) begin
            state_nxt   = PRESSED;
            deb_cnt_nxt = '0;
          end else begin
            deb_cnt_nxt = deb_cnt_q + DEB_W'(1);
          end
        end
        PRESSED: begin
          hold_cnt_nxt = hold_cnt_inc;
          if (!pressed_s) begin
            state_nxt   = RELEASE_PEND;
            deb_cnt_nxt = DEB_W'(1);
          end
        end
        RELEASE_PEND: begin
          hold_cnt_nxt = hold_cnt_inc;
          if (pressed_s) begin
            state_nxt   = PRESSED;
            deb_cnt_nxt = '0;
          end else if (deb_cnt_q >= DEB_LAST) begin
            state_nxt    = RELEASED;
            deb_cnt_nxt  = '0;
            hold_cnt_nxt = '0;
          end else begin
            deb_cnt_nxt = deb_cnt_q + DEB_W'(1);
          end
        end
        default: begin
          state_nxt    = RELEASED;
          deb_cnt_nxt  = '0;
          hold_cnt_nxt = '0;
        end
      endcase
    end

    // Output decode from the transition about to be taken.
    always_comb begin
      level_nxt   = (state_nxt == PRESSED) || (state_nxt == RELEASE_PEND);
      press_nxt   = (state_q == PRESS_PEND) && (state_nxt == PRESSED);
      release_nxt = (state_q == RELEASE_PEND) && (state_nxt == RELEASED);
      long_nxt    = (hold_cnt_q != HOLD_MAX) && (hold_cnt_nxt == HOLD_MAX);
    end

    // Registered outputs so downstream logic sees glitch-free signals.
    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
      if (reset) begin
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        level_q   <= level_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        long_q    <= long_nxt;
      end
    end

    assign key_level[k]   = level_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_long[k]    = long_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer
// Directed stimulus for key_debouncer with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=20. A run-length model of the debounce rule is checked
// against the outputs after every clock edge, and hand-computed literal
// expectations pin the key latencies and pulse counts.
module tb_key_debouncer;

  localparam int NK   = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic          MAX10_CLK1_50;
  logic          reset;
  logic [NK-1:0] KEY;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // Behavioural model state.
  logic [NK-1:0] hist_new;
  logic [NK-1:0] hist_old;
  logic [NK-1:0] model_lvl;
  int            run_len [NK];
  int            held    [NK];
  logic [NK-1:0] exp_level;
  logic [NK-1:0] exp_press;
  logic [NK-1:0] exp_release;
  logic [NK-1:0] exp_long;

  // Observed pulse bookkeeping.
  int press_cnt   [NK];
  int release_cnt [NK];
  int long_cnt    [NK];
  int last_press  [NK];
  int last_release[NK];
  int last_long   [NK];

  int snap_press;
  int snap_release;
  int snap_long;

  key_debouncer #(
    .NUM_KEYS         (NK),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG)
  ) dut (
    .MAX10_CLK1_50(MAX10_CLK1_50),
    .reset        (reset),
    .KEY          (KEY),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release),
    .key_long     (key_long)
  );

  initial MAX10_CLK1_50 = 1'b0;
  always #5 MAX10_CLK1_50 = ~MAX10_CLK1_50;

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %b, want %b", name, cycle,
               actual, expected);
    end
  endtask

  // Drive KEY at a falling edge, then let n more falling edges pass.
  task automatic applyStimulus(input logic [NK-1:0] key_value, input int n);
    KEY = key_value;
    repeat (n) @(negedge MAX10_CLK1_50);
  endtask

  task automatic modelReset();
    hist_new    = '1;
    hist_old    = '1;
    model_lvl   = '0;
    exp_level   = '0;
    exp_press   = '0;
    exp_release = '0;
    exp_long    = '0;
    for (int k = 0; k < NK; k++) begin
      run_len[k] = 0;
      held[k]    = 0;
    end
  endtask

  // One clock edge of the model: the pressed sample lags KEY by two edges,
  // and the level flips once the sample has disagreed with it DEB times in
  // a row. Long press counts edges spent at level 1 after acceptance.
  task automatic modelStep();
    for (int k = 0; k < NK; k++) begin
      logic s_now;
      s_now       = ~hist_old[k];
      hist_old[k] = hist_new[k];
      hist_new[k] = KEY[k];
      exp_press[k]   = 1'b0;
      exp_release[k] = 1'b0;
      exp_long[k]    = 1'b0;
      if (s_now != model_lvl[k]) run_len[k]++;
      else run_len[k] = 0;
      if (run_len[k] == DEB) begin
        run_len[k]   = 0;
        model_lvl[k] = s_now;
        held[k]      = 0;
        if (s_now) exp_press[k] = 1'b1;
        else exp_release[k] = 1'b1;
      end else if (model_lvl[k] && held[k] < LONG) begin
        held[k]++;
        if (held[k] == LONG) exp_long[k] = 1'b1;
      end
      exp_level[k] = model_lvl[k];
    end
  endtask

  // Compare process: advance the model each edge and check just after it.
  initial begin : compare_proc
    for (int k = 0; k < NK; k++) begin
      press_cnt[k]    = 0;
      release_cnt[k]  = 0;
      long_cnt[k]     = 0;
      last_press[k]   = 0;
      last_release[k] = 0;
      last_long[k]    = 0;
    end
    forever begin
      @(posedge MAX10_CLK1_50);
      if (reset) modelReset();
      else modelStep();
      #1;
      cycle++;
      checkOutput("model_level",   8'(key_level),   8'(exp_level));
      checkOutput("model_press",   8'(key_press),   8'(exp_press));
      checkOutput("model_release", 8'(key_release), 8'(exp_release));
      checkOutput("model_long",    8'(key_long),    8'(exp_long));
      for (int k = 0; k < NK; k++) begin
        if (key_press[k]) begin
          press_cnt[k]++;
          last_press[k] = cycle;
        end
        if (key_release[k]) begin
          release_cnt[k]++;
          last_release[k] = cycle;
        end
        if (key_long[k]) begin
          long_cnt[k]++;
          last_long[k] = cycle;
        end
      end
    end
  end

  initial begin : stimulus_proc
    reset = 1'b1;
    KEY   = 2'b11;
    repeat (3) @(negedge MAX10_CLK1_50);
    checkOutput("reset_outputs", {key_level, key_press, key_release, key_long},
                8'h00);
    reset = 1'b0;
    applyStimulus(2'b11, 4);

    // Clean press on KEY[0]: pulse and level exactly 6 edges after the fall.
    applyStimulus(2'b10, 5);
    checkOutput("clean_level_early", 8'(key_level), 8'b00);
    checkOutput("clean_press_early", 8'(key_press), 8'b00);
    applyStimulus(2'b10, 1);
    checkOutput("clean_level", 8'(key_level), 8'b01);
    checkOutput("clean_press", 8'(key_press), 8'b01);
    applyStimulus(2'b10, 1);
    checkOutput("clean_press_width", 8'(key_press), 8'b00);
    snap_long = long_cnt[0];
    applyStimulus(2'b10, 18);
    checkOutput("long_early", 8'(key_long), 8'b00);
    applyStimulus(2'b10, 1);
    checkOutput("long_pulse", 8'(key_long), 8'b01);
    applyStimulus(2'b10, 1);
    checkOutput("long_width", 8'(key_long), 8'b00);
    applyStimulus(2'b10, 6);
    checkOutput("long_once", 8'(long_cnt[0] - snap_long), 8'd1);
    checkOutput("long_delay", 8'(last_long[0] - last_press[0]), 8'd20);
    applyStimulus(2'b11, 5);
    checkOutput("release_level_early", 8'(key_level), 8'b01);
    applyStimulus(2'b11, 1);
    checkOutput("release_level", 8'(key_level), 8'b00);
    checkOutput("release_pulse", 8'(key_release), 8'b01);
    applyStimulus(2'b11, 10);

    // Short hold of 10 cycles: no long pulse.
    snap_long = long_cnt[0];
    applyStimulus(2'b10, 10);
    applyStimulus(2'b11, 40);
    checkOutput("short_no_long", 8'(long_cnt[0] - snap_long), 8'd0);
    checkOutput("short_hold_span", 8'(last_release[0] - last_press[0]), 8'd10);

    // Bounce before a steady press: exactly one press, 6 after final fall.
    snap_press = press_cnt[0];
    applyStimulus(2'b10, 2);
    applyStimulus(2'b11, 1);
    applyStimulus(2'b10, 3);
    applyStimulus(2'b11, 1);
    applyStimulus(2'b10, 5);
    checkOutput("bounce_level_early", 8'(key_level), 8'b00);
    applyStimulus(2'b10, 1);
    checkOutput("bounce_press", 8'(key_press), 8'b01);
    applyStimulus(2'b10, 10);
    checkOutput("bounce_single", 8'(press_cnt[0] - snap_press), 8'd1);
    applyStimulus(2'b11, 12);

    // Release glitch of 3 cycles while held: level stays, long still on time.
    snap_release = release_cnt[0];
    snap_long    = long_cnt[0];
    applyStimulus(2'b10, 6);
    checkOutput("glitch_press", 8'(key_press), 8'b01);
    applyStimulus(2'b10, 4);
    applyStimulus(2'b11, 3);
    applyStimulus(2'b10, 30);
    checkOutput("glitch_level", 8'(key_level), 8'b01);
    checkOutput("glitch_no_release", 8'(release_cnt[0] - snap_release), 8'd0);
    checkOutput("glitch_long_once", 8'(long_cnt[0] - snap_long), 8'd1);
    checkOutput("glitch_long_delay", 8'(last_long[0] - last_press[0]), 8'd20);
    applyStimulus(2'b11, 12);

    // Both keys fall together; releases independent.
    applyStimulus(2'b00, 6);
    checkOutput("both_press", 8'(key_press), 8'b11);
    checkOutput("both_level", 8'(key_level), 8'b11);
    snap_release = release_cnt[0];
    applyStimulus(2'b00, 2);
    applyStimulus(2'b10, 10);
    checkOutput("both_level_split", 8'(key_level), 8'b01);
    checkOutput("both_rel0_none", 8'(release_cnt[0] - snap_release), 8'd0);
    applyStimulus(2'b11, 12);

    // Reset while pressed, released with KEY[0] still low.
    applyStimulus(2'b10, 7);
    checkOutput("pre_reset_level", 8'(key_level), 8'b01);
    snap_release = release_cnt[0];
    reset = 1'b1;
    #1;
    checkOutput("async_reset_outputs",
                {key_level, key_press, key_release, key_long}, 8'h00);
    repeat (2) @(negedge MAX10_CLK1_50);
    reset = 1'b0;
    applyStimulus(2'b10, 5);
    checkOutput("rearm_level_early", 8'(key_level), 8'b00);
    applyStimulus(2'b10, 1);
    checkOutput("rearm_press", 8'(key_press), 8'b01);
    checkOutput("rearm_no_release", 8'(release_cnt[0] - snap_release), 8'd0);
    applyStimulus(2'b11, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
